// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end.
// Holds the button index map, the button count, the auto-repeat state
// encoding and a helper that sizes counters safely for tiny parameters.
package btn_pkg;

   localparam int NUM_BTNS = 5;

   localparam int BTN_U = 4;
   localparam int BTN_D = 3;
   localparam int BTN_R = 2;
   localparam int BTN_L = 1;
   localparam int BTN_C = 0;

   typedef enum logic [1:0] {
      RPT_IDLE      = 2'd0,
      RPT_WAIT_HOLD = 2'd1,
      RPT_REPEATING = 2'd2
   } rpt_state_e;

   // $clog2 returns 0 for n<=1; keep at least one bit so vectors stay legal.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit synchroniser, debouncer and press-edge detector.
// Ports:
//   clk      in   board clock, all state on rising edge
//   rst      in   synchronous active-high reset
//   raw_i    in   raw asynchronous pad level
//   level_o  out  debounced level (registered)
//   press_o  out  one-clk pulse when level_o goes 0->1 (registered)
//   rise_o   out  combinational: level_o will rise on the next edge
//   fall_o   out  combinational: level_o will fall on the next edge
module btn_debounce
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic             level_q;
   logic             level_d;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Any sample that agrees with the debounced level restarts the count,
   // so only an unbroken run of disagreeing samples can flip the level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (s2_q != level_q) begin
         if (cnt_q == CNT_TC) begin
            level_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign rise_o = level_d & ~level_q;
   assign fall_o = ~level_d & level_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         s1_q    <= raw_i;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= rise_o;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Front end for the five push-buttons {U,D,R,L,C}: synchronise, debounce and
// emit a one-clk press strobe per debounced press.
// Optional feature macro: BTN_AUTOREPEAT_EN -- when defined, U and D emit
// repeat strobes while held (first after HOLD_CYCLES, then every
// REPEAT_CYCLES); when undefined no repeat logic exists and repeat_active=0.
// Ports:
//   clk            in   board clock
//   rst            in   synchronous active-high reset
//   btn_raw[4:0]   in   raw pads {U,D,R,L,C}
//   btn_level[4:0] out  debounced levels
//   btn_press[4:0] out  one-clk press / repeat strobes
//   repeat_active  out  {U,D} in repeat phase
module button_conditioner
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 20_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BTNS-1:0] btn_raw,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [1:0]          repeat_active
);

   logic [NUM_BTNS-1:0] deb_press;
   logic [NUM_BTNS-1:0] deb_rise;
   logic [NUM_BTNS-1:0] deb_fall;
   logic                unused_deb;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_deb
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk     (clk),
         .rst     (rst),
         .raw_i   (btn_raw[i]),
         .level_o (btn_level[i]),
         .press_o (deb_press[i]),
         .rise_o  (deb_rise[i]),
         .fall_o  (deb_fall[i])
      );
   end

   // Edge strobes are only consumed for U/D, and only with auto-repeat.
   assign unused_deb = ^{deb_rise, deb_fall};

`ifdef BTN_AUTOREPEAT_EN

   localparam int HCNT_W = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
   localparam logic [HCNT_W-1:0] HOLD_TC = HCNT_W'(HOLD_CYCLES - 1);
   localparam logic [HCNT_W-1:0] REP_TC  = HCNT_W'(REPEAT_CYCLES - 1);

   logic [1:0] rpt_press;

   // j=1 -> U, j=0 -> D, matching the {U,D} order of repeat_active.
   for (genvar j = 0; j < 2; j++) begin : g_rpt
      localparam int IDX = (j == 1) ? BTN_U : BTN_D;

      rpt_state_e        state_q;
      logic [HCNT_W-1:0] hcnt_q;
      logic              rpt_press_q;
      logic              active_q;

      // The FSM leaves idle on the same edge that raises the press strobe,
      // so the first repeat lands exactly HOLD_CYCLES after that strobe.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q     <= RPT_IDLE;
            hcnt_q      <= '0;
            rpt_press_q <= 1'b0;
            active_q    <= 1'b0;
         end else begin
            rpt_press_q <= 1'b0;
            if (deb_fall[IDX]) begin
               state_q  <= RPT_IDLE;
               hcnt_q   <= '0;
               active_q <= 1'b0;
            end else begin
               case (state_q)
                  RPT_IDLE: begin
                     if (deb_rise[IDX]) begin
                        state_q <= RPT_WAIT_HOLD;
                        hcnt_q  <= '0;
                     end
                  end
                  RPT_WAIT_HOLD: begin
                     if (hcnt_q == HOLD_TC) begin
                        rpt_press_q <= 1'b1;
                        state_q     <= RPT_REPEATING;
                        hcnt_q      <= '0;
                        active_q    <= 1'b1;
                     end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                     end
                  end
                  RPT_REPEATING: begin
                     if (hcnt_q == REP_TC) begin
                        rpt_press_q <= 1'b1;
                        hcnt_q      <= '0;
                     end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                     end
                  end
                  default: begin
                     state_q  <= RPT_IDLE;
                     hcnt_q   <= '0;
                     active_q <= 1'b0;
                  end
               endcase
            end
         end
      end

      assign rpt_press[j]     = rpt_press_q;
      assign repeat_active[j] = active_q;
   end

   always_comb begin
      btn_press        = deb_press;
      btn_press[BTN_U] = deb_press[BTN_U] | rpt_press[1];
      btn_press[BTN_D] = deb_press[BTN_D] | rpt_press[0];
   end

`else

   assign btn_press     = deb_press;
   assign repeat_active = 2'b00;

`endif

endmodule
